// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, baud_tick oversampling, mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 framing with an rx_parity_err output.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_wire,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_error,
`ifdef UART_RX_PARITY_EN
    output logic                 rx_parity_err,
`endif
    output logic                 rx_busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   error_q, error_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], rx_wire};
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (baud_tick) begin
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end
                StStart: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StData: begin
                    // tick_cnt wraps to 0 on the sample, so the next sample is one bit later
                    tick_d = tick_q + 1'b1;
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == TICK_LAST) begin
                        par_d   = rx_s;
                        state_d = StStop;
                    end
                end
`endif
                StStop: begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == TICK_LAST) begin
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_d  = (^shift_q) ^ par_q;
`endif
                            state_d = StIdle;
                        end else begin
                            error_d = 1'b1;
                            state_d = StBreak;
                        end
                    end
                end
                StBreak: begin
                    // hold off until the line returns high so a stuck-low line cannot retrigger
                    if (rx_s) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_error = error_q;
    assign rx_busy  = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the existing uart_tx.
- Oversamples the serial line using the shared baud_tick strobe.
- Recovers one data byte per frame and presents it as a parallel byte with a one-cycle valid strobe.
- Sits between the pad-level serial input and the byte-oriented host logic; reports framing errors.

Parameters:
- OVERSAMPLE, 8, baud_tick strobes per bit period; power of two, min 4.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_tick  input  1  single-clk-cycle enable, OVERSAMPLE per bit period, synchronous to clk.
- rx_wire  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last good received byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- rx_error  output  1  one-cycle pulse: framing error (stop bit sampled low).
- rx_busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Synchroniser:
  - rx_wire passes through a 2-flop synchroniser; both flops reset to 1.
  - All logic below uses the synchronised value rx_s.
- Reset values: rx_data=0, rx_valid=0, rx_error=0, rx_busy=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame: no rx_valid, no rx_error, rx_data unchanged from its reset value.
- Tick gating: counters and sampling advance only on clk edges where baud_tick=1; no other state changes except the output pulses and synchroniser.
- tick_cnt: log2(OVERSAMPLE) bits, wraps naturally.
- bit_cnt: log2(DATA_BITS) bits.
- States:
  - IDLE:
    - On a tick with rx_s=0, go to START, clear tick_cnt, set rx_busy=1.
  - START:
    - Count ticks. When tick_cnt reaches OVERSAMPLE/2-1 (mid-bit), sample rx_s.
    - Sample=0: go to DATA, clear tick_cnt and bit_cnt.
    - Sample=1: false start; go to IDLE, rx_busy=0, no pulses.
  - DATA:
    - Sample rx_s when tick_cnt reaches OVERSAMPLE-1 (one full bit after the previous sample).
    - Shift the sample into the shift register at the MSB end, so the LSB-first line order yields correct bit order.
    - Increment bit_cnt. After DATA_BITS samples, go to STOP.
  - STOP:
    - Sample at the next full-bit point.
    - Sample=1: load rx_data from the shift register, pulse rx_valid, go to IDLE, rx_busy=0.
    - Sample=0: pulse rx_error, leave rx_data unchanged, go to BREAK.
  - BREAK:
    - Wait for a tick with rx_s=1, then go to IDLE, rx_busy=0.
    - Prevents a held-low line from retriggering frames.
- Latency: rx_valid/rx_error asserts on the clk edge that follows the tick sampling the stop bit, and stays high exactly one clk cycle.
- rx_data holds until the next good frame.
- Back-to-back frames:
  - The IDLE transition after the stop sample allows a start bit immediately after the stop mid-point.
  - No dead time beyond half a bit is required.
- No overrun detection. The consumer must capture rx_data before the next rx_valid, within one frame time.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a PARITY state between DATA and STOP samples one extra bit.
  - Even parity is checked over the data bits plus the parity bit.
  - Extra output port rx_parity_err (1 bit, reset 0): one-cycle pulse coincident with rx_valid when parity mismatches.
  - rx_data is still updated on parity mismatch.
  - A framing error takes precedence: rx_error pulses and rx_parity_err stays 0.
- Undefined:
  - No PARITY state and no rx_parity_err port; behaviour exactly as above.

Test Plan:
- Send 0xA5 as 8N1 at OVERSAMPLE=8: line bits 0,1,0,1,0,0,1,0,1,1 → rx_data=0xA5; rx_valid high 1 cycle; rx_error=0; rx_busy falls the same cycle.
- Line low for 2 ticks, then high → no rx_valid/rx_error; rx_busy pulses high then returns 0 at the mid-start sample; state returns to IDLE.
- Send 0x3C with the stop bit driven low, line held low 20 more ticks, then 0x81 sent normally:
  - rx_error one pulse; rx_data unchanged.
  - No frame is detected during the held-low period.
  - Then rx_data=0x81 with rx_valid.
- Back-to-back 0x55 then 0xFF with no idle gap → two rx_valid pulses, 80 ticks apart; data 0x55 then 0xFF.
- Assert rst during data bit 4 of 0x0F, release, then send 0x42 → no pulses from the aborted frame; rx_data=0 after reset, then 0x42.
- With UART_RX_PARITY_EN:
  - 0x07 with parity bit 1 → rx_valid, rx_parity_err=0.
  - 0x07 with parity bit 0 → rx_valid and rx_parity_err in the same cycle.
